// File: rtl/verin_pio_out.sv
// verin_pio_out: Avalon-MM slave output PIO that drives the actuator (verin)
// command lines. It has an output data register with atomic set/clear access.
// A refresh watchdog returns the outputs to RESET_VALUE when software stops
// rewriting them. On expiry it latches a sticky timed_out flag, and that flag
// can raise a level interrupt.
//
// Bus handshake: a transfer is a write when chipselect=1 and write_n=0 on a
// rising clk edge. The write is committed on that edge, and there is no
// waitrequest or back-pressure. Reads have no strobe. readdata is re-registered
// every clock from the address present at the edge, so read data is valid
// exactly one cycle after the address is presented, whatever chipselect is.
module verin_pio_out #(
    parameter int                 WIDTH       = 2,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    parameter int                 TMR_W       = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port,
    output logic              irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RELOAD   = 3'd1;
    localparam logic [2:0] ADDR_STATUS   = 3'd2;
    localparam logic [2:0] ADDR_OUTSET   = 3'd3;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd4;
    localparam logic [2:0] ADDR_CONTROL  = 3'd5;

    localparam logic [TMR_W-1:0] TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

    // Architectural state
    logic [WIDTH-1:0] out_reg;
    logic [TMR_W-1:0] reload_reg;
    logic [TMR_W-1:0] counter;
    logic             timed_out;
    logic             irq_en;

    // Decoded write strobes
    logic             wr;
    logic             wr_data;
    logic             wr_reload;
    logic             wr_status;
    logic             wr_outset;
    logic             wr_outclear;
    logic             wr_control;
    logic             reload_hit;

    // Next-state values
    logic [TMR_W-1:0] reload_next;
    logic [TMR_W-1:0] counter_next;
    logic [WIDTH-1:0] out_next;
    logic             timed_out_next;
    logic             expire;
    logic             running;
    logic [31:0]      rd_next;

    // Writedata bits above WIDTH/TMR_W have no destination in this block.
    logic             unused_writedata;
    assign unused_writedata = &{1'b0, writedata};

    assign running  = (counter != '0);
    assign out_port = out_reg;

    // Address decode of the single-cycle write strobe
    always_comb begin
        wr          = chipselect & ~write_n;
        wr_data     = wr & (address == ADDR_DATA);
        wr_reload   = wr & (address == ADDR_RELOAD);
        wr_status   = wr & (address == ADDR_STATUS);
        wr_outset   = wr & (address == ADDR_OUTSET);
        wr_outclear = wr & (address == ADDR_OUTCLEAR);
        wr_control  = wr & (address == ADDR_CONTROL);
        // Any write that touches the outputs, or the timeout itself, re-arms the watchdog
        reload_hit  = wr_data | wr_outset | wr_outclear | wr_reload;
    end

    // Watchdog: reload on refresh, otherwise count down and saturate at zero.
    // A refresh on the terminal cycle wins over expiry.
    always_comb begin
        reload_next  = wr_reload ? writedata[TMR_W-1:0] : reload_reg;
        counter_next = counter;
        expire       = 1'b0;
        if (reload_hit) begin
            counter_next = reload_next;
        end else if (running) begin
            counter_next = counter - TMR_ONE;
            expire       = (counter == TMR_ONE);
        end
    end

    // Output register next value: bus writes first, then the watchdog safe value
    always_comb begin
        out_next = out_reg;
        if (wr_data) begin
            out_next = writedata[WIDTH-1:0];
        end else if (wr_outset) begin
            out_next = out_reg | writedata[WIDTH-1:0];
        end else if (wr_outclear) begin
            out_next = out_reg & ~writedata[WIDTH-1:0];
        end else if (expire) begin
            out_next = RESET_VALUE;
        end
    end

    // Sticky timeout flag: expiry sets it and takes priority over a write-1-to-clear
    always_comb begin
        timed_out_next = timed_out;
        if (expire) begin
            timed_out_next = 1'b1;
        end else if (wr_status && writedata[0]) begin
            timed_out_next = 1'b0;
        end
    end

    // Read mux: zero-extended register images, write-only and reserved read as 0
    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = out_reg;
            ADDR_RELOAD:  rd_next[TMR_W-1:0] = reload_reg;
            ADDR_STATUS:  rd_next[1:0]       = {running, timed_out};
            ADDR_CONTROL: rd_next[0]         = irq_en;
            default:      rd_next            = '0;
        endcase
    end

    // Output data register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg <= RESET_VALUE;
        end else begin
            out_reg <= out_next;
        end
    end

    // Watchdog reload register and down-counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload_reg <= '0;
            counter    <= '0;
        end else begin
            reload_reg <= reload_next;
            counter    <= counter_next;
        end
    end

    // Status and control flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timed_out <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            timed_out <= timed_out_next;
            if (wr_control) begin
                irq_en <= writedata[0];
            end
        end
    end

    // Registered interrupt and read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            irq      <= timed_out & irq_en;
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_verin_pio_out.sv
// Testbench for verin_pio_out. A deadline-based reference model predicts the
// outputs and readdata after every clock edge. The tests are directed scenarios
// followed by randomized bus traffic.
module tb_verin_pio_out;

    localparam int W = 2;
    localparam logic [W-1:0] RV = 2'b00;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] out_port;
    logic        irq;

    int n_vec;
    int n_err;

    // Reference model: the watchdog is an absolute expiry cycle number (deadline)
    int          cyc;
    int          dl;
    logic        dl_valid;
    logic [W-1:0] m_out;
    logic [23:0] m_reload;
    logic        m_to;
    logic        m_ien;
    logic        m_irq;
    logic [31:0] m_rd;

    verin_pio_out #(.WIDTH(W), .RESET_VALUE(RV), .TMR_W(24)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        dl_valid = 1'b0;
        dl       = 0;
        m_out    = RV;
        m_reload = '0;
        m_to     = 1'b0;
        m_ien    = 1'b0;
        m_irq    = 1'b0;
        m_rd     = '0;
    endtask

    // One rising edge of the model with the bus inputs present at that edge
    task automatic model_edge(input logic w, input logic [2:0] a, input logic [31:0] d);
        logic running_pre;
        logic hit;
        logic expire;
        cyc++;
        running_pre = dl_valid && (dl >= cyc);
        case (a)
            3'd0:    m_rd = {30'd0, m_out};
            3'd1:    m_rd = {8'd0, m_reload};
            3'd2:    m_rd = {30'd0, running_pre, m_to};
            3'd5:    m_rd = {31'd0, m_ien};
            default: m_rd = 32'd0;
        endcase
        m_irq  = m_to & m_ien;
        hit    = w && (a == 3'd0 || a == 3'd1 || a == 3'd3 || a == 3'd4);
        expire = !hit && dl_valid && (dl == cyc);
        if (w) begin
            case (a)
                3'd0:    m_out = d[W-1:0];
                3'd1:    m_reload = d[23:0];
                3'd3:    m_out = m_out | d[W-1:0];
                3'd4:    m_out = m_out & ~d[W-1:0];
                3'd5:    m_ien = d[0];
                default: ;
            endcase
        end
        if (hit) begin
            if (m_reload == 24'd0) begin
                dl_valid = 1'b0;
            end else begin
                dl_valid = 1'b1;
                dl       = cyc + int'(m_reload);
            end
        end
        if (expire) begin
            m_out    = RV;
            m_to     = 1'b1;
            dl_valid = 1'b0;
        end else if (w && a == 3'd2 && d[0]) begin
            m_to = 1'b0;
        end
    endtask

    // Driver: apply a bus cycle at the falling edge, advance model at the rising edge
    task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        @(posedge clk);
        model_edge(cs & ~wn, a, d);
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (out_port !== 2'b00) begin n_err++; $display("FAIL reset_out: got %0h expected 0", out_port); end
        n_vec++;
        if (readdata !== 32'd0) begin n_err++; $display("FAIL reset_rd: got %0h expected 0", readdata); end
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %0b expected 0", irq); end
        #2 reset_n = 1'b1;
        for (int a = 0; a < 3; a++) begin
            step(1'b1, 1'b1, 3'(a), 32'd0);
            n_vec++;
            if (readdata !== 32'd0 || readdata !== m_rd) begin
                n_err++; $display("FAIL reset_read%0d: got %0h expected 0", a, readdata);
            end
            n_vec++;
            if (out_port !== 2'b00) begin n_err++; $display("FAIL reset_out_after: got %0h expected 0", out_port); end
        end
    endtask

    task automatic test_data_ops();
        logic [31:0] wd [3];
        logic [2:0]  wa [3];
        logic [W-1:0] exp_out [3];
        wa = '{3'd0, 3'd4, 3'd3};
        wd = '{32'h3, 32'h1, 32'h0};
        exp_out = '{2'b11, 2'b10, 2'b10};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, wa[i], wd[i]);
            n_vec++;
            if (out_port !== exp_out[i] || out_port !== m_out) begin
                n_err++; $display("FAIL data_op%0d: got %0h expected %0h", i, out_port, exp_out[i]);
            end
        end
        step(1'b1, 1'b1, 3'd3, 32'd0);
        n_vec++;
        if (readdata !== 32'd0) begin n_err++; $display("FAIL read_outset: got %0h expected 0", readdata); end
        step(1'b1, 1'b1, 3'd4, 32'd0);
        n_vec++;
        if (readdata !== 32'd0) begin n_err++; $display("FAIL read_outclear: got %0h expected 0", readdata); end
        step(1'b1, 1'b1, 3'd0, 32'd0);
        n_vec++;
        if (readdata !== 32'h2 || readdata !== m_rd) begin
            n_err++; $display("FAIL read_data: got %0h expected 2", readdata);
        end
    endtask

    task automatic test_watchdog_expiry();
        step(1'b1, 1'b0, 3'd1, 32'd10);
        step(1'b1, 1'b0, 3'd5, 32'd1);
        step(1'b1, 1'b0, 3'd0, 32'd1);
        n_vec++;
        if (out_port !== 2'b01) begin n_err++; $display("FAIL wd_start: got %0h expected 1", out_port); end
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1, 3'd2, 32'd0);
            n_vec++;
            if (out_port !== ((i < 10) ? 2'b01 : 2'b00) || out_port !== m_out) begin
                n_err++; $display("FAIL wd_count%0d: got %0h expected %0h", i, out_port, m_out);
            end
        end
        step(1'b1, 1'b1, 3'd2, 32'd0);
        n_vec++;
        if (readdata !== 32'h1 || readdata !== m_rd) begin
            n_err++; $display("FAIL wd_status: got %0h expected 1", readdata);
        end
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL wd_irq: got %0b expected 1", irq); end
        step(1'b1, 1'b0, 3'd2, 32'd1);
        step(1'b1, 1'b1, 3'd2, 32'd0);
        n_vec++;
        if (irq !== 1'b0 || irq !== m_irq) begin n_err++; $display("FAIL wd_irq_clear: got %0b expected 0", irq); end
        n_vec++;
        if (readdata !== 32'd0) begin n_err++; $display("FAIL wd_status_clear: got %0h expected 0", readdata); end
    endtask

    task automatic test_refresh();
        step(1'b1, 1'b0, 3'd1, 32'd5);
        for (int k = 0; k < 13; k++) begin
            step(1'b1, 1'b0, 3'd0, 32'($urandom_range(0, 3)));
            n_vec++;
            if (out_port !== m_out) begin n_err++; $display("FAIL refresh_out: got %0h expected %0h", out_port, m_out); end
            for (int j = 0; j < 3; j++) begin
                step(1'b1, 1'b1, 3'd2, 32'd0);
                n_vec++;
                if (readdata !== 32'h2 || readdata !== m_rd) begin
                    n_err++; $display("FAIL refresh_status: got %0h expected 2", readdata);
                end
            end
        end
        // Refresh that lands exactly on the terminal count
        step(1'b1, 1'b0, 3'd0, 32'h2);
        repeat (4) step(1'b1, 1'b1, 3'd0, 32'd0);
        step(1'b1, 1'b0, 3'd0, 32'h1);
        n_vec++;
        if (out_port !== 2'b01 || out_port !== m_out) begin
            n_err++; $display("FAIL edge_refresh_out: got %0h expected 1", out_port);
        end
        step(1'b1, 1'b1, 3'd2, 32'd0);
        n_vec++;
        if (readdata !== 32'h2 || readdata !== m_rd) begin
            n_err++; $display("FAIL edge_refresh_status: got %0h expected 2", readdata);
        end
    endtask

    task automatic test_simultaneous();
        step(1'b1, 1'b0, 3'd1, 32'd3);
        step(1'b1, 1'b0, 3'd0, 32'h2);
        repeat (2) step(1'b1, 1'b1, 3'd0, 32'd0);
        // Status clear on the expiry edge: the set wins
        step(1'b1, 1'b0, 3'd2, 32'd1);
        n_vec++;
        if (out_port !== 2'b00 || out_port !== m_out) begin
            n_err++; $display("FAIL sim_expire_out: got %0h expected 0", out_port);
        end
        step(1'b1, 1'b1, 3'd2, 32'd0);
        n_vec++;
        if (readdata !== 32'h1 || readdata !== m_rd) begin
            n_err++; $display("FAIL sim_set_wins: got %0h expected 1", readdata);
        end
        step(1'b1, 1'b0, 3'd2, 32'd1);
        step(1'b1, 1'b1, 3'd2, 32'd0);
        n_vec++;
        if (readdata !== 32'h0 || readdata !== m_rd) begin
            n_err++; $display("FAIL sim_clear: got %0h expected 0", readdata);
        end
    endtask

    task automatic test_reload_stop();
        step(1'b1, 1'b0, 3'd1, 32'd8);
        step(1'b1, 1'b0, 3'd0, 32'h3);
        repeat (3) step(1'b1, 1'b1, 3'd0, 32'd0);
        step(1'b1, 1'b0, 3'd1, 32'd0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 3'd2, 32'd0);
            n_vec++;
            if (out_port !== 2'b11 || readdata !== 32'd0) begin
                n_err++; $display("FAIL reload_stop%0d: got out %0h status %0h expected out 3 status 0", i, out_port, readdata);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 3'd1, 32'd6);
        step(1'b1, 1'b0, 3'd0, 32'h3);
        repeat (2) step(1'b1, 1'b1, 3'd0, 32'd0);
        n_vec++;
        if (out_port !== 2'b11) begin n_err++; $display("FAIL mid_pre: got %0h expected 3", out_port); end
        #2 reset_n = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (out_port !== 2'b00) begin n_err++; $display("FAIL mid_async_out: got %0h expected 0", out_port); end
        n_vec++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            n_err++; $display("FAIL mid_async_rd_irq: got %0h/%0b expected 0/0", readdata, irq);
        end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, (i == 11) ? 3'd5 : 3'd2, 32'd0);
            n_vec++;
            if (readdata !== 32'd0 || irq !== 1'b0 || out_port !== 2'b00) begin
                n_err++; $display("FAIL mid_after%0d: got rd %0h irq %0b out %0h expected 0", i, readdata, irq, out_port);
            end
        end
    endtask

    task automatic test_random();
        logic        cs;
        logic        wn;
        logic [2:0]  a;
        logic [31:0] d;
        for (int i = 0; i < 800; i++) begin
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 4) != 0);
            a  = 3'($urandom_range(0, 7));
            d  = $urandom;
            if (a == 3'd1) d = (d & 32'hFF00_0000) | 32'($urandom_range(0, 12));
            step(cs, wn, a, d);
            n_vec++;
            if (out_port !== m_out) begin n_err++; $display("FAIL rand_out%0d: got %0h expected %0h", i, out_port, m_out); end
            n_vec++;
            if (readdata !== m_rd) begin n_err++; $display("FAIL rand_rd%0d: got %0h expected %0h", i, readdata, m_rd); end
            n_vec++;
            if (irq !== m_irq) begin n_err++; $display("FAIL rand_irq%0d: got %0b expected %0b", i, irq, m_irq); end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        test_reset();
        test_data_ops();
        test_watchdog_expiry();
        test_refresh();
        test_simultaneous();
        test_reload_stop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
